// File: rtl/wb_stage_reg_if.sv
// MEM -> WB bus for the MEM/WB pipeline register: write-back candidates,
// load-align controls, and the register-file write port / forwarding tap.
interface wb_stage_reg_if #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
);
   logic            in_valid;
   logic            stall;
   logic            flush;
   logic [1:0]      wd_sel;
   logic [XLEN-1:0] pc4;
   logic [XLEN-1:0] alu_c;
   logic [XLEN-1:0] dram_i;
   logic [XLEN-1:0] imm;
   logic [2:0]      ld_funct3;
   logic [1:0]      ld_addr_lo;
   logic [RA_W-1:0] rd_in;
   logic            we_in;

   logic            wb_valid;
   logic            rf_we;
   logic [RA_W-1:0] rf_wa;
   logic [XLEN-1:0] rf_wd;
   logic            fwd_hit_en;

   // The MEM stage drives the candidates; the WB register answers with the RF port.
   modport master (
      output in_valid, stall, flush, wd_sel, pc4, alu_c, dram_i, imm,
             ld_funct3, ld_addr_lo, rd_in, we_in,
      input  wb_valid, rf_we, rf_wa, rf_wd, fwd_hit_en
   );

   modport slave (
      input  in_valid, stall, flush, wd_sel, pc4, alu_c, dram_i, imm,
             ld_funct3, ld_addr_lo, rd_in, we_in,
      output wb_valid, rf_we, rf_wa, rf_wd, fwd_hit_en
   );
endinterface

// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register with write-back source select, stall/flush and x0 suppression.
// Define WB_LOAD_ALIGN_EN to align and extend sub-word loads here instead of upstream.
module wb_stage_reg #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic          clk,
   input  logic          rst,
   wb_stage_reg_if.slave bus
);

   typedef enum logic [1:0] {
      SEL_PC4  = 2'b00,
      SEL_ALU  = 2'b01,
      SEL_DRAM = 2'b10,
      SEL_IMM  = 2'b11
   } wd_sel_e;

   typedef enum logic [2:0] {
      LD_LB  = 3'b000,
      LD_LH  = 3'b001,
      LD_LW  = 3'b010,
      LD_LBU = 3'b100,
      LD_LHU = 3'b101
   } ld_funct3_e;

   logic [XLEN-1:0] w_loadData;
   logic [XLEN-1:0] w_selData;
   logic            w_writeEn;

   logic            r_wbValid;
   logic            r_rfWe;
   logic [RA_W-1:0] r_rfWa;
   logic [XLEN-1:0] r_rfWd;

`ifdef WB_LOAD_ALIGN_EN
   logic [7:0]  w_ldByte;
   logic [15:0] w_ldHalf;
   logic [31:0] w_ldWord;

   // Byte lane picked by the low address bits; halfword lane by bit 1 only,
   // since misaligned halfwords never reach this stage.
   always_comb begin
      w_ldWord = bus.dram_i[31:0];
      w_ldHalf = bus.ld_addr_lo[1] ? w_ldWord[31:16] : w_ldWord[15:0];
      unique case (bus.ld_addr_lo)
         2'd0:    w_ldByte = w_ldWord[7:0];
         2'd1:    w_ldByte = w_ldWord[15:8];
         2'd2:    w_ldByte = w_ldWord[23:16];
         default: w_ldByte = w_ldWord[31:24];
      endcase
   end

   always_comb begin
      w_loadData = bus.dram_i;
      case (ld_funct3_e'(bus.ld_funct3))
         LD_LB:   w_loadData = XLEN'($signed(w_ldByte));
         LD_LBU:  w_loadData = XLEN'(w_ldByte);
         LD_LH:   w_loadData = XLEN'($signed(w_ldHalf));
         LD_LHU:  w_loadData = XLEN'(w_ldHalf);
         LD_LW:   w_loadData = XLEN'($signed(w_ldWord));
         default: w_loadData = bus.dram_i;
      endcase
   end
`else
   logic w_unusedLd;

   assign w_unusedLd = ^{bus.ld_funct3, bus.ld_addr_lo};
   assign w_loadData = bus.dram_i;
`endif

   always_comb begin
      w_selData = bus.alu_c;
      case (wd_sel_e'(bus.wd_sel))
         SEL_PC4:  w_selData = bus.pc4;
         SEL_ALU:  w_selData = bus.alu_c;
         SEL_DRAM: w_selData = w_loadData;
         SEL_IMM:  w_selData = bus.imm;
         default:  w_selData = bus.alu_c;
      endcase
   end

   // Writes to x0 are dropped here so the register file never needs to filter them.
   assign w_writeEn = bus.in_valid & bus.we_in & (bus.rd_in != '0);

   // Priority: reset, then flush (bubble, even while stalled), then stall (hold).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wbValid <= 1'b0;
         r_rfWe    <= 1'b0;
         r_rfWa    <= '0;
         r_rfWd    <= '0;
      end else if (bus.flush) begin
         r_wbValid <= 1'b0;
         r_rfWe    <= 1'b0;
         r_rfWa    <= bus.rd_in;
         r_rfWd    <= w_selData;
      end else if (!bus.stall) begin
         r_wbValid <= bus.in_valid;
         r_rfWe    <= w_writeEn;
         r_rfWa    <= bus.rd_in;
         r_rfWd    <= w_selData;
      end
   end

   assign bus.wb_valid   = r_wbValid;
   assign bus.rf_we      = r_rfWe;
   assign bus.rf_wa      = r_rfWa;
   assign bus.rf_wd      = r_rfWd;
   assign bus.fwd_hit_en = r_rfWe;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Testbench for wb_stage_reg: directed vector table, hand sequences for
// stall/flush/reset interplay, and randomized traffic against a reference model.
module tb_wb_stage_reg;

`ifdef WB_LOAD_ALIGN_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   typedef struct {
      logic        inValid;
      logic        stall;
      logic        flush;
      logic        weIn;
      logic [4:0]  rd;
      logic [1:0]  wdSel;
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic [31:0] pc4;
      logic [31:0] alu;
      logic [31:0] dram;
      logic [31:0] imm;
      logic        expValid;
      logic        expWe;
      logic [4:0]  expWa;
      logic [31:0] expWd;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic        mValid;
   logic        mWe;
   logic [4:0]  mWa;
   logic [31:0] mWd;

   wb_stage_reg_if #(.XLEN(32), .RA_W(5)) bus ();

   wb_stage_reg #(.XLEN(32), .RA_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mkVec(logic inValid, logic weIn, logic [4:0] rd, logic [1:0] wdSel,
                                  logic [31:0] pc4, logic [31:0] alu, logic [31:0] dram,
                                  logic [31:0] imm, logic [2:0] f3, logic [1:0] lo,
                                  logic expValid, logic expWe, logic [4:0] expWa,
                                  logic [31:0] expWd);
      vec_t v;
      v.inValid = inValid; v.stall = 1'b0; v.flush = 1'b0; v.weIn = weIn;
      v.rd = rd; v.wdSel = wdSel; v.f3 = f3; v.lo = lo;
      v.pc4 = pc4; v.alu = alu; v.dram = dram; v.imm = imm;
      v.expValid = expValid; v.expWe = expWe; v.expWa = expWa; v.expWd = expWd;
      return v;
   endfunction

   // Expected write data from the source-select and load-extension rules.
   function automatic logic [31:0] refData(vec_t v);
      logic [31:0] b;
      logic [31:0] h;
      if (v.wdSel == 2'b00) return v.pc4;
      if (v.wdSel == 2'b01) return v.alu;
      if (v.wdSel == 2'b11) return v.imm;
      if (!ALIGN) return v.dram;
      b = (v.dram >> (8 * v.lo)) & 32'hFF;
      h = (v.dram >> (16 * (v.lo / 2))) & 32'hFFFF;
      case (v.f3)
         3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'b100:  return b;
         3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'b101:  return h;
         default: return v.dram;
      endcase
   endfunction

   task automatic modelStep(vec_t v, logic r);
      if (r) begin
         mValid = 1'b0; mWe = 1'b0; mWa = '0; mWd = '0;
      end else if (v.flush) begin
         mValid = 1'b0; mWe = 1'b0; mWa = v.rd; mWd = refData(v);
      end else if (!v.stall) begin
         mValid = v.inValid;
         mWe    = v.inValid && v.weIn && (v.rd != 0);
         mWa    = v.rd;
         mWd    = refData(v);
      end
   endtask

   task automatic applyStimulus(vec_t v, logic r);
      rst            = r;
      bus.in_valid   = v.inValid;
      bus.stall      = v.stall;
      bus.flush      = v.flush;
      bus.we_in      = v.weIn;
      bus.rd_in      = v.rd;
      bus.wd_sel     = v.wdSel;
      bus.ld_funct3  = v.f3;
      bus.ld_addr_lo = v.lo;
      bus.pc4        = v.pc4;
      bus.alu_c      = v.alu;
      bus.dram_i     = v.dram;
      bus.imm        = v.imm;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(string name, logic eValid, logic eWe, logic [4:0] eWa,
                              logic [31:0] eWd);
      checks++;
      if (bus.wb_valid !== eValid) begin
         failures++;
         $display("[TB] FAIL %s wb_valid: got %0b expected %0b", name, bus.wb_valid, eValid);
      end
      checks++;
      if (bus.rf_we !== eWe || bus.fwd_hit_en !== eWe) begin
         failures++;
         $display("[TB] FAIL %s rf_we/fwd_hit_en: got %0b/%0b expected %0b", name,
                  bus.rf_we, bus.fwd_hit_en, eWe);
      end
      checks++;
      if (bus.rf_wa !== eWa) begin
         failures++;
         $display("[TB] FAIL %s rf_wa: got %0d expected %0d", name, bus.rf_wa, eWa);
      end
      checks++;
      if (bus.rf_wd !== eWd) begin
         failures++;
         $display("[TB] FAIL %s rf_wd: got %08h expected %08h", name, bus.rf_wd, eWd);
      end
   endtask

   initial begin
      vec_t tbl[$];
      vec_t v;
      checks   = 0;
      failures = 0;

      tbl.push_back(mkVec(1, 1, 5, 2'b01, 0, 32'h1234, 0, 0, 3'b010, 0, 1, 1, 5, 32'h1234));
      tbl.push_back(mkVec(1, 1, 6, 2'b00, 32'h104, 32'hA, 32'hB, 32'h12345000, 3'b010, 0, 1, 1, 6, 32'h104));
      tbl.push_back(mkVec(1, 1, 6, 2'b01, 32'h104, 32'hA, 32'hB, 32'h12345000, 3'b010, 0, 1, 1, 6, 32'hA));
      tbl.push_back(mkVec(1, 1, 6, 2'b10, 32'h104, 32'hA, 32'hB, 32'h12345000, 3'b010, 0, 1, 1, 6, 32'hB));
      tbl.push_back(mkVec(1, 1, 6, 2'b11, 32'h104, 32'hA, 32'hB, 32'h12345000, 3'b010, 0, 1, 1, 6, 32'h12345000));
      tbl.push_back(mkVec(1, 1, 0, 2'b01, 0, 32'h55, 0, 0, 3'b010, 0, 1, 0, 0, 32'h55));
      tbl.push_back(mkVec(0, 1, 3, 2'b01, 0, 32'h66, 0, 0, 3'b010, 0, 0, 0, 3, 32'h66));
      tbl.push_back(mkVec(1, 1, 8, 2'b10, 0, 0, 32'h80FF7F81, 0, 3'b000, 0, 1, 1, 8, ALIGN ? 32'hFFFFFF81 : 32'h80FF7F81));
      tbl.push_back(mkVec(1, 1, 8, 2'b10, 0, 0, 32'h80FF7F81, 0, 3'b100, 0, 1, 1, 8, ALIGN ? 32'h00000081 : 32'h80FF7F81));
      tbl.push_back(mkVec(1, 1, 8, 2'b10, 0, 0, 32'h80FF7F81, 0, 3'b000, 1, 1, 1, 8, ALIGN ? 32'h0000007F : 32'h80FF7F81));
      tbl.push_back(mkVec(1, 1, 8, 2'b10, 0, 0, 32'h80FF7F81, 0, 3'b001, 2, 1, 1, 8, ALIGN ? 32'hFFFF80FF : 32'h80FF7F81));
      tbl.push_back(mkVec(1, 1, 8, 2'b10, 0, 0, 32'h80FF7F81, 0, 3'b101, 2, 1, 1, 8, ALIGN ? 32'h000080FF : 32'h80FF7F81));
      tbl.push_back(mkVec(1, 1, 8, 2'b10, 0, 0, 32'h80FF7F81, 0, 3'b010, 0, 1, 1, 8, 32'h80FF7F81));
      tbl.push_back(mkVec(1, 1, 8, 2'b10, 0, 0, 32'h80FF7F81, 0, 3'b000, 3, 1, 1, 8, ALIGN ? 32'hFFFFFF80 : 32'h80FF7F81));
      tbl.push_back(mkVec(1, 1, 8, 2'b10, 0, 0, 32'h80FF7F81, 0, 3'b100, 2, 1, 1, 8, ALIGN ? 32'h000000FF : 32'h80FF7F81));
      tbl.push_back(mkVec(1, 1, 8, 2'b10, 0, 0, 32'h80FF7F81, 0, 3'b101, 0, 1, 1, 8, ALIGN ? 32'h00007F81 : 32'h80FF7F81));
      tbl.push_back(mkVec(1, 1, 8, 2'b10, 0, 0, 32'h80FF7F81, 0, 3'b001, 3, 1, 1, 8, ALIGN ? 32'hFFFF80FF : 32'h80FF7F81));
      tbl.push_back(mkVec(1, 1, 8, 2'b10, 0, 0, 32'h80FF7F81, 0, 3'b011, 1, 1, 1, 8, 32'h80FF7F81));

      // Reset state
      v = mkVec(1, 1, 9, 2'b01, 0, 32'hDEAD, 0, 0, 3'b010, 0, 0, 0, 0, 0);
      applyStimulus(v, 1'b1);
      applyStimulus(v, 1'b1);
      checkOutput("reset", 0, 0, 0, 0);

      foreach (tbl[i]) begin
         applyStimulus(tbl[i], 1'b0);
         checkOutput($sformatf("vec%0d", i), tbl[i].expValid, tbl[i].expWe, tbl[i].expWa,
                     tbl[i].expWd);
      end

      // Stall holds a committed write, flush during stall bubbles it
      v = mkVec(1, 1, 7, 2'b01, 0, 32'h7, 0, 0, 3'b010, 0, 0, 0, 0, 0);
      applyStimulus(v, 1'b0);
      checkOutput("load_rd7", 1, 1, 7, 32'h7);
      v.rd = 9; v.alu = 32'h9; v.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(v, 1'b0);
         checkOutput($sformatf("stall%0d", i), 1, 1, 7, 32'h7);
      end
      v.flush = 1'b1;
      applyStimulus(v, 1'b0);
      checkOutput("stall_flush", 0, 0, 9, 32'h9);

      // Flush without stall
      v = mkVec(1, 1, 4, 2'b11, 0, 0, 0, 32'hABC000, 3'b010, 0, 0, 0, 0, 0);
      v.flush = 1'b1;
      applyStimulus(v, 1'b0);
      checkOutput("flush_only", 0, 0, 4, 32'hABC000);

      // Reset while stalled clears everything and leaves no residual write
      v = mkVec(1, 1, 12, 2'b01, 0, 32'hC0FFEE, 0, 0, 3'b010, 0, 0, 0, 0, 0);
      applyStimulus(v, 1'b0);
      checkOutput("pre_reset", 1, 1, 12, 32'hC0FFEE);
      v.stall = 1'b1;
      applyStimulus(v, 1'b1);
      checkOutput("reset_in_stall", 0, 0, 0, 0);
      applyStimulus(v, 1'b0);
      checkOutput("after_reset_stall", 0, 0, 0, 0);

      // Randomized traffic against the model
      mValid = 1'b0; mWe = 1'b0; mWa = '0; mWd = '0;
      for (int n = 0; n < 400; n++) begin
         logic r;
         v.inValid = $urandom_range(0, 3) != 0;
         v.stall   = $urandom_range(0, 3) == 0;
         v.flush   = $urandom_range(0, 7) == 0;
         v.weIn    = $urandom_range(0, 4) != 0;
         v.rd      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
         v.wdSel   = 2'($urandom);
         v.f3      = 3'($urandom);
         v.lo      = 2'($urandom);
         v.pc4     = $urandom;
         v.alu     = $urandom;
         v.dram    = $urandom;
         v.imm     = $urandom;
         r = ($urandom_range(0, 39) == 0) || (n == 0);
         applyStimulus(v, r);
         modelStep(v, r);
         checkOutput($sformatf("rand%0d", n), mValid, mWe, mWa, mWd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_stage_reg.md
Name: wb_stage_reg

Overview:
- Parametrised MEM/WB pipeline register with the integrated write-back source select.
- Captures the four write-back candidates (pc+4, ALU result, DRAM read data, immediate) one cycle after MEM.
- Produces the register-file write port (we/rd/data) and a forwarding tap for the EX-stage bypass.
- Supports stall (hold) and flush (bubble), suppresses writes to x0, and optionally aligns and sign-extends sub-word loads.

Parameters:
- XLEN, 32, datapath width in bits (32 or 64).
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  MEM stage holds a real instruction this cycle.
- stall  in  1  hold WB register contents.
- flush  in  1  replace incoming instruction with a bubble.
- wd_sel  in  2  write-back source: 00 pc4 (jal/jalr), 01 alu_c, 10 dram_i (loads), 11 imm (lui).
- pc4  in  XLEN  pc+4 of the MEM instruction.
- alu_c  in  XLEN  ALU result.
- dram_i  in  XLEN  raw DRAM read word.
- imm  in  XLEN  U-type immediate.
- ld_funct3  in  3  load funct3 (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
- ld_addr_lo  in  2  alu_c[1:0] of the load address.
- rd_in  in  RA_W  destination register.
- we_in  in  1  instruction writes rd.
- wb_valid  out  1  WB register holds a real instruction.
- rf_we  out  1  register-file write enable.
- rf_wa  out  RA_W  register-file write address.
- rf_wd  out  XLEN  register-file write data.
- fwd_hit_en  out  1  forwarding tap valid; equals rf_we.

Behaviour:
- Source select is combinational on the inputs and is fully decoded; there is no latch path.
  - wd_sel=10 routes dram_i through the load-align unit (see Optional Feature) before selection.
- Latency: exactly 1 cycle. A value presented in cycle N appears on rf_* in cycle N+1 and is written to the RF on the N+1 edge.
- Update priority at each rising edge, evaluated in this order:
  - rst=1: wb_valid=0, rf_we=0, rf_wa=0, rf_wd=0. Reset mid-stall or mid-flush clears everything; no residual write after rst deasserts.
  - flush=1 (with or without stall): wb_valid=0, rf_we=0. rf_wa and rf_wd are loaded normally (don't-care, but deterministic).
  - stall=1: all outputs hold their previous values. A held rf_we=1 keeps re-writing the same value, which is idempotent and allowed.
  - otherwise: wb_valid<=in_valid, rf_wa<=rd_in, rf_wd<=selected data, rf_we<=in_valid & we_in & (rd_in!=0).
- x0 rule: rd_in=0 never asserts rf_we, regardless of we_in.
- in_valid=0 means a bubble: rf_we=0, data still captured.
- All arithmetic is zero- or sign-extension to XLEN only; there are no adds.
- fwd_hit_en=rf_we, and fwd data/addr are rf_wd/rf_wa (no separate registers).

Optional Feature:
- Macro WB_LOAD_ALIGN_EN.
- Defined: when wd_sel=10, dram_i is aligned and extended by ld_funct3:
  - lb: byte at ld_addr_lo, sign-extended.
  - lbu: same byte, zero-extended.
  - lh: halfword at ld_addr_lo[1], sign-extended.
  - lhu: same halfword, zero-extended.
  - lw: full word, sign-extended to XLEN if XLEN=64.
  - ld_addr_lo[0]=1 on lh/lhu uses halfword ld_addr_lo[1]; misalignment is trapped upstream.
  - Undefined funct3 passes dram_i unchanged.
- Undefined: ld_funct3 and ld_addr_lo are ignored; dram_i passes unchanged, and the load unit upstream does alignment.

Test Plan:
- Reset, then one cycle with in_valid=1, we_in=1, rd_in=5, wd_sel=01, alu_c=0x0000_1234 -> next cycle rf_we=1, rf_wa=5, rf_wd=0x0000_1234, wb_valid=1.
- Sweep wd_sel with pc4=0x104, alu_c=0xA, dram_i=0xB, imm=0x12345000 -> rf_wd is 0x104, 0xA, 0xB, 0x12345000 respectively, each one cycle later.
- rd_in=0, we_in=1, in_valid=1 -> rf_we=0, wb_valid=1. Then in_valid=0, rd_in=3 -> rf_we=0, wb_valid=0.
- Load value 7 into rd=7, then stall=1 for 3 cycles while inputs change to rd=9 -> outputs frozen at rd=7. Then stall=1 with flush=1 -> rf_we=0, wb_valid=0. Then rst asserted during stall -> all outputs 0 next cycle.
- WB_LOAD_ALIGN_EN defined, dram_i=0x80FF_7F81, wd_sel=10:
  - lb, lo=0 -> 0xFFFF_FF81.
  - lbu, lo=0 -> 0x0000_0081.
  - lb, lo=1 -> 0x0000_007F.
  - lh, lo=2 -> 0xFFFF_80FF.
  - lhu, lo=2 -> 0x0000_80FF.
  - lw -> 0x80FF_7F81.
- WB_LOAD_ALIGN_EN undefined, same stimulus -> rf_wd=0x80FF_7F81 for every funct3.
